// File: rtl/bcd_counter_mux7.sv
// Multi-digit BCD up/down counter with load and wrap flag, plus a time-multiplexed
// common-anode 7-segment driver. Everything runs on clk using clock-enable ticks.
module bcd_counter_mux7 #(
    parameter int DIGITS      = 4,
    parameter int STEP_DIV    = 50000000,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  upDown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [6:0]            seg7,
    output logic [DIGITS-1:0]     an
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] STEP_LAST    = SW'(STEP_DIV - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(DIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [SW-1:0]          step_cnt_reg;
    logic [RW-1:0]          refresh_cnt_reg;
    logic [IW-1:0]          idx_reg;
    logic [4*DIGITS-1:0]    count_reg;
    logic                   tc_reg;
    logic [DIGITS-1:0]      an_reg;
    logic [6:0]             seg7_reg;

    logic                   step_tick;
    logic                   refresh_tick;
    logic [3:0]             digit [DIGITS];
    logic [DIGITS-1:0]      dig_nine;
    logic [DIGITS-1:0]      dig_zero;
    logic [DIGITS-1:0]      upper_zero;
    logic [4*DIGITS-1:0]    inc_val;
    logic [4*DIGITS-1:0]    dec_val;
    logic [4*DIGITS-1:0]    load_clean;
    logic [DIGITS-1:0]      an_next;
    logic [6:0]             seg7_next;
    logic [3:0]             cur_digit;
    logic                   cur_blank;

    assign step_tick    = (step_cnt_reg == STEP_LAST);
    assign refresh_tick = (refresh_cnt_reg == REFRESH_LAST);

    // Carry/borrow into digit gi is the AND of the lower digits' 9/0 flags,
    // so the whole ripple resolves combinationally within one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic carry_in;
            logic borrow_in;

            assign digit[gi]    = count_reg[4*gi +: 4];
            assign dig_nine[gi] = (digit[gi] == 4'd9);
            assign dig_zero[gi] = (digit[gi] == 4'd0);

            if (gi == 0) begin : g_lsd
                assign carry_in  = 1'b1;
                assign borrow_in = 1'b1;
            end else begin : g_upper
                assign carry_in  = &dig_nine[gi-1:0];
                assign borrow_in = &dig_zero[gi-1:0];
            end

            assign upper_zero[gi] = &dig_zero[DIGITS-1:gi];

            assign inc_val[4*gi +: 4] = !carry_in ? digit[gi] :
                                        (dig_nine[gi] ? 4'd0 : digit[gi] + 4'd1);
            assign dec_val[4*gi +: 4] = !borrow_in ? digit[gi] :
                                        (dig_zero[gi] ? 4'd9 : digit[gi] - 4'd1);

            assign load_clean[4*gi +: 4] = (load_val[4*gi +: 4] > 4'd9) ? 4'd0
                                                                        : load_val[4*gi +: 4];

            assign an_next[gi] = (idx_reg != IW'(gi));
        end
    endgenerate

    assign cur_digit = digit[idx_reg];
    assign cur_blank = (BLANK_LZ != 0) && (idx_reg != '0) && upper_zero[idx_reg];
    assign seg7_next = cur_blank ? 7'b1111111 : seg_decode(cur_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_reg    <= '0;
            refresh_cnt_reg <= '0;
            idx_reg         <= '0;
        end else begin
            step_cnt_reg    <= step_tick ? '0 : step_cnt_reg + SW'(1);
            refresh_cnt_reg <= refresh_tick ? '0 : refresh_cnt_reg + RW'(1);
            if (refresh_tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else if (load) begin
            count_reg <= load_clean;
            tc_reg    <= 1'b0;
        end else if (step_tick && enable) begin
            count_reg <= upDown ? inc_val : dec_val;
            tc_reg    <= upDown ? (&dig_nine) : (&dig_zero);
        end else begin
            tc_reg    <= 1'b0;
        end
    end

    // Display path is registered: it reflects idx/count from the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg   <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg7_reg <= 7'b1000000;
        end else begin
            an_reg   <= an_next;
            seg7_reg <= seg7_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign an    = an_reg;
    assign seg7  = seg7_reg;

endmodule

// File: tb/tb_bcd_counter_mux7.sv
// Directed bench: a 2-digit fast-stepping instance for counting/load behaviour and
// a 4-digit instance for step pacing, reset restart and display scanning/blanking.
module tb_bcd_counter_mux7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, up_a, load_a;
    logic [7:0]  lv_a, count_a;
    logic        tc_a;
    logic [6:0]  seg_a;
    logic [1:0]  an_a;

    logic        rst_b, en_b, up_b, load_b;
    logic [15:0] lv_b, count_b;
    logic        tc_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bcd_counter_mux7 #(.DIGITS(2), .STEP_DIV(1), .REFRESH_DIV(1), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .upDown(up_a), .load(load_a),
        .load_val(lv_a), .count(count_a), .tc(tc_a), .seg7(seg_a), .an(an_a)
    );

    bcd_counter_mux7 #(.DIGITS(4), .STEP_DIV(5), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .upDown(up_b), .load(load_b),
        .load_val(lv_b), .count(count_b), .tc(tc_b), .seg7(seg_b), .an(an_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d a: count=%h tc=%b | b: count=%h tc=%b an=%b seg=%b",
                 cyc, count_a, tc_a, count_b, tc_b, an_b, seg_b);
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_v;
        int idx;
        logic [3:0] e_an;
        logic [6:0] e_seg;

        rst_a = 1'b1; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lv_a = '0;
        rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; lv_b = '0;

        // Reset state of the 2-digit instance
        step();
        check("a_rst_count", count_a, 8'h00);
        check("a_rst_tc", tc_a, 1'b0);
        check("a_rst_an", an_a, 2'b10);
        check("a_rst_seg", seg_a, 7'b1000000);

        // Count up through full range and wrap
        rst_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        exp_v = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_v = (exp_v + 1) % 100;
            check("up_count", count_a, bcd2(exp_v));
            check("up_tc", tc_a, (exp_v == 0));
        end

        // Load 00 then count down: wrap to 99 with tc, then 98
        load_a = 1'b1; lv_a = 8'h00;
        step();
        check("load00_count", count_a, 8'h00);
        check("load00_tc", tc_a, 1'b0);
        load_a = 1'b0; up_a = 1'b0;
        step();
        check("down_wrap_count", count_a, 8'h99);
        check("down_wrap_tc", tc_a, 1'b1);
        step();
        check("down_98_count", count_a, 8'h98);
        check("down_98_tc", tc_a, 1'b0);

        // Invalid nibble is loaded as 0
        load_a = 1'b1; lv_a = 8'h3C;
        step();
        check("load_3C", count_a, 8'h30);

        // Load wins over a simultaneous step tick
        up_a = 1'b1; en_a = 1'b1; lv_a = 8'h42;
        step();
        check("load_prio", count_a, 8'h42);
        check("load_prio_tc", tc_a, 1'b0);
        load_a = 1'b0; en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_count", count_a, 8'h42);
            check("hold_tc", tc_a, 1'b0);
        end

        // 4-digit instance: reset state, then STEP_DIV=5 pacing
        step();
        check("b_rst_count", count_b, 16'h0000);
        check("b_rst_tc", tc_b, 1'b0);
        check("b_rst_an", an_b, 4'b1110);
        check("b_rst_seg", seg_b, 7'b1000000);
        rst_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("step5_count", count_b, 16'(k / 5));
        end
        rst_b = 1'b1;
        step();
        check("midrst_count", count_b, 16'h0000);
        check("midrst_tc", tc_b, 1'b0);
        rst_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("after_rst_count", count_b, (k == 5) ? 16'h0001 : 16'h0000);
        end

        // Scan and blanking: reset, load 0007, later 0100
        en_b = 1'b0; rst_b = 1'b1;
        step();
        rst_b = 1'b0; load_b = 1'b1; lv_b = 16'h0007;
        for (int n = 1; n <= 40; n++) begin
            step();
            idx  = ((n - 1) / 4) % 4;
            e_an = ~(4'b0001 << idx);
            if (n == 1) begin
                e_seg = 7'b1000000;
            end else if (n <= 21) begin
                e_seg = (idx == 0) ? 7'b1111000 : 7'b1111111;
            end else begin
                case (idx)
                    0, 1:    e_seg = 7'b1000000;
                    2:       e_seg = 7'b1111001;
                    default: e_seg = 7'b1111111;
                endcase
            end
            check("scan_an", an_b, e_an);
            check("scan_seg", seg_b, e_seg);
            if (n == 1) begin
                check("scan_load7", count_b, 16'h0007);
                load_b = 1'b0;
            end
            if (n == 20) begin
                load_b = 1'b1; lv_b = 16'h0100;
            end
            if (n == 21) begin
                check("scan_load100", count_b, 16'h0100);
                load_b = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_mux7.md
Name: bcd_counter_mux7

Overview:
- Parametrised successor to the single-digit 4-bit counter/7-seg path.
- Holds a DIGITS-wide BCD up/down counter with synchronous load and terminal-count flag.
- Drives a time-multiplexed common-anode 7-segment display from the same clock.
- Uses clock-enable ticks instead of a divided clock, so the whole block runs on clk.

Parameters:
- DIGITS, 4: number of BCD digits; range 1..8.
- STEP_DIV, 50000000: clk cycles per count step; >=1, where 1 means every cycle.
- REFRESH_DIV, 50000: clk cycles per display digit slot; >=1.
- BLANK_LZ, 1: 1 blanks leading zeros on digits above digit 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  count enable, sampled on step tick
- upDown  in  1  1 = count up, 0 = count down
- load  in  1  synchronous parallel load
- load_val  in  4*DIGITS  BCD load value; digit i at [4i+3:4i]
- count  out  4*DIGITS  current BCD value
- tc  out  1  one-cycle pulse on wrap
- seg7  out  7  active-low segments; bit0 = a ... bit6 = g
- an  out  DIGITS  active-low one-hot digit select; an[0] = least significant digit

Behaviour:
- Reset (rst=1 at posedge), all registers clear:
  - count=0, tc=0, step and refresh dividers=0, scan index=0.
  - an={DIGITS{1}} with bit0=0.
  - seg7=7'b1000000 (glyph "0").
- Step tick: divider counts 0..STEP_DIV-1. Tick is high in the cycle it equals STEP_DIV-1, then it returns to 0. First tick comes STEP_DIV cycles after rst deasserts.
- Refresh tick: same scheme with REFRESH_DIV. It is independent of the step tick.
- Priority, evaluated each cycle: rst > load > (step_tick & enable) > hold.
- Load:
  - count <= load_val in the next edge, regardless of tick or enable.
  - Any nibble >9 is loaded as 0.
  - tc=0.
  - The step divider is not disturbed.
- Count up:
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple within one cycle).
  - All digits at 9 -> all 0, and tc=1 for exactly that cycle.
- Count down:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All 0 -> all 9, and tc=1.
- enable=0 on a tick: count holds, tc=0.
- upDown is sampled only on the tick edge. A direction change between ticks has no other effect.
- tc is registered. It is high the cycle after the wrapping edge, same cycle count shows the wrapped value.
- Scan:
  - On each refresh tick, the index advances 0,1,...,DIGITS-1,0.
  - an and seg7 are registered: they show the index and count as sampled on the previous edge (1-cycle latency).
  - Exactly one an bit is low at all times after reset.
- Decode, for values 0-9 (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Blanking: with BLANK_LZ=1, digit i>0 shows seg7=1111111 when digits i..DIGITS-1 are all 0. Digit 0 is never blanked.
- Reset mid-scan or mid-count: everything restarts from the reset state next cycle. No partial-step carry-over.
- DIGITS=1 is legal: scan index stays 0, an=0.

Test Plan:
1. DIGITS=2, STEP_DIV=1, rst pulse then enable=1, upDown=1 for 100 cycles -> count goes 00,01,...,09,10,...,99,00. tc high only the cycle count=00 after 99.
2. Same params, load_val=8'h00, load=1 for one cycle, then upDown=0 -> count 99 in 1 step. tc pulses. Next value is 98. Also load_val=8'h3C -> count=8'h30 (nibble C loaded as 0).
3. load=1 and step tick with enable=1 in the same cycle, load_val=8'h42 -> count=8'h42, not 43. enable=0 for 10 ticks -> count unchanged, tc=0.
4. STEP_DIV=5 -> after rst deasserts, count changes first at the 5th edge and every 5 edges thereafter. rst asserted mid-interval -> count=0 and the next change comes 5 edges after release.
5. DIGITS=4, REFRESH_DIV=4, count=16'h0007, BLANK_LZ=1 -> an cycles 1110, 1101, 1011, 0111 every 4 cycles. seg7 reads 1111000 on digit 0 and 1111111 on digits 1-3. With count=16'h0100, digit 1 shows 1000000 (not blanked).
6. Reset check -> count=0, tc=0, an=...1110, seg7=1000000 on the first edge with rst=1.
